// File: rtl/lu_row_arbiter_if.sv
// Bundle of LU read, LU write-back, host and row-RAM signals for lu_row_arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface lu_row_arbiter_if #(
   parameter int SIZE  = 16,
   parameter int WIDTH = 64
);
   localparam int RW = SIZE * 2 * WIDTH;
   localparam int AW = $clog2(SIZE);

   logic          rd_req_valid_i;
   logic [AW-1:0] rd_req_addr_i;
   logic          rd_req_ready_o;
   logic [RW-1:0] rd_row_o;
   logic [AW-1:0] rd_row_addr_o;
   logic          rd_row_valid_o;

   logic          wr_valid_i;
   logic [AW-1:0] wr_addr_i;
   logic [RW-1:0] wr_row_i;
   logic          wr_ready_o;

   logic          host_valid_i;
   logic          host_we_i;
   logic [AW-1:0] host_addr_i;
   logic [RW-1:0] host_wdata_i;
   logic          host_ready_o;
   logic [RW-1:0] host_rdata_o;
   logic          host_rvalid_o;

   logic          ram_en_o;
   logic          ram_we_o;
   logic [AW-1:0] ram_addr_o;
   logic [RW-1:0] ram_wdata_o;
   logic [RW-1:0] ram_rdata_i;

   modport slave (
      input  rd_req_valid_i, rd_req_addr_i,
      output rd_req_ready_o, rd_row_o, rd_row_addr_o, rd_row_valid_o,
      input  wr_valid_i, wr_addr_i, wr_row_i,
      output wr_ready_o,
      input  host_valid_i, host_we_i, host_addr_i, host_wdata_i,
      output host_ready_o, host_rdata_o, host_rvalid_o,
      output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
      input  ram_rdata_i
   );

   modport master (
      output rd_req_valid_i, rd_req_addr_i,
      input  rd_req_ready_o, rd_row_o, rd_row_addr_o, rd_row_valid_o,
      output wr_valid_i, wr_addr_i, wr_row_i,
      input  wr_ready_o,
      output host_valid_i, host_we_i, host_addr_i, host_wdata_i,
      input  host_ready_o, host_rdata_o, host_rvalid_o,
      input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
      output ram_rdata_i
   );
endinterface

// File: rtl/lu_row_arbiter.sv
// Single-port row RAM arbiter: LU reads, 2-deep LU write-back buffer, aged host access.
// Define LU_ARB_FWD_EN to forward hazarding reads from the write buffer instead of stalling.
module lu_row_arbiter #(
   parameter int SIZE      = 16,
   parameter int WIDTH     = 64,
   parameter int AGE_LIMIT = 8
) (
   input  logic           clk_i,
   input  logic           rst_i,
   lu_row_arbiter_if.slave bus
);
   localparam int RW  = SIZE * 2 * WIDTH;
   localparam int AW  = $clog2(SIZE);
   localparam int AGW = $clog2(AGE_LIMIT + 1);

   typedef enum logic [1:0] {GntNone, GntDrain, GntHost, GntRead} gnt_e;
   typedef enum logic [1:0] {TagNone, TagLu, TagHost} tag_e;

   logic          alive_q;
   logic [1:0]    count_q, count_d;
   logic          head_q, head_d;
   logic [AW-1:0] fifo_addr_q [2];
   logic [RW-1:0] fifo_row_q [2];
   logic [AGW-1:0] age_q, age_d;
   tag_e          tag_q, tag_d;
   logic          fwd_q, fwd_d;
   logic [RW-1:0] fwd_row_q, fwd_row_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [RW-1:0] rd_row_q, host_row_q;
   logic [AW-1:0] last_addr_q;
   logic [RW-1:0] last_wdata_q;

   gnt_e          gnt;
   logic          full, nonempty, tail, wr_slot, push, pop;
   logic [1:0]    ent_vld, rd_match, host_match;
   logic          rd_hit, host_hit, rd_ok, host_ok, rd_fwd, host_fwd, aged;
   logic [RW-1:0] rd_fwd_row, host_fwd_row, resp_row;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [RW-1:0] ram_wdata;

   assign full     = (count_q == 2'd2);
   assign nonempty = (count_q != 2'd0);
   assign tail     = ~head_q;
   assign wr_slot  = head_q ^ count_q[0];
   assign aged     = (age_q == AGW'(AGE_LIMIT));

   always_comb begin
      ent_vld[0] = full || (count_q == 2'd1 && !head_q);
      ent_vld[1] = full || (count_q == 2'd1 && head_q);
      for (int i = 0; i < 2; i++) begin
         rd_match[i]   = ent_vld[i] && (fifo_addr_q[i] == bus.rd_req_addr_i);
         host_match[i] = ent_vld[i] && (fifo_addr_q[i] == bus.host_addr_i);
      end
   end

   assign rd_hit   = |rd_match;
   assign host_hit = !bus.host_we_i && (|host_match);

   // Only the tail slot can be younger than the head, and only when both are valid.
   assign rd_fwd_row   = rd_match[tail]   ? fifo_row_q[tail] : fifo_row_q[head_q];
   assign host_fwd_row = host_match[tail] ? fifo_row_q[tail] : fifo_row_q[head_q];

`ifdef LU_ARB_FWD_EN
   assign rd_ok    = bus.rd_req_valid_i;
   assign host_ok  = bus.host_valid_i;
   assign rd_fwd   = rd_hit;
   assign host_fwd = host_hit;
`else
   assign rd_ok    = bus.rd_req_valid_i && !rd_hit;
   assign host_ok  = bus.host_valid_i && !host_hit;
   assign rd_fwd   = 1'b0;
   assign host_fwd = 1'b0;
`endif

   always_comb begin
      gnt = GntNone;
      if (!alive_q)             gnt = GntNone;
      else if (full)            gnt = GntDrain;
      else if (aged && host_ok) gnt = GntHost;
      else if (rd_ok)           gnt = GntRead;
      else if (nonempty)        gnt = GntDrain;
      else if (host_ok)         gnt = GntHost;
   end

   assign push = bus.wr_valid_i && bus.wr_ready_o;
   assign pop  = (gnt == GntDrain);

   // RAM command; address and write data hold their last value when not driven.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = last_addr_q;
      ram_wdata = last_wdata_q;
      unique case (gnt)
         GntDrain: begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = fifo_addr_q[head_q];
            ram_wdata = fifo_row_q[head_q];
         end
         GntHost: begin
            ram_en   = !host_fwd;
            ram_we   = bus.host_we_i;
            ram_addr = bus.host_addr_i;
            if (bus.host_we_i) ram_wdata = bus.host_wdata_i;
         end
         GntRead: begin
            ram_en   = !rd_fwd;
            ram_addr = bus.rd_req_addr_i;
         end
         default: ;
      endcase
   end

   always_comb begin
      count_d   = count_q + {1'b0, push} - {1'b0, pop};
      head_d    = pop ? ~head_q : head_q;
      age_d     = age_q;
      tag_d     = TagNone;
      fwd_d     = 1'b0;
      fwd_row_d = fwd_row_q;
      rd_addr_d = rd_addr_q;
      if (!bus.host_valid_i || bus.host_ready_o) age_d = '0;
      else if (!aged)                            age_d = age_q + AGW'(1);
      if (gnt == GntRead) begin
         tag_d     = TagLu;
         rd_addr_d = bus.rd_req_addr_i;
         fwd_d     = rd_fwd;
         if (rd_fwd) fwd_row_d = rd_fwd_row;
      end else if (gnt == GntHost && !bus.host_we_i) begin
         tag_d = TagHost;
         fwd_d = host_fwd;
         if (host_fwd) fwd_row_d = host_fwd_row;
      end
   end

   assign resp_row = fwd_q ? fwd_row_q : bus.ram_rdata_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alive_q      <= 1'b0;
         count_q      <= 2'd0;
         head_q       <= 1'b0;
         age_q        <= '0;
         tag_q        <= TagNone;
         fwd_q        <= 1'b0;
         fwd_row_q    <= '0;
         rd_addr_q    <= '0;
         rd_row_q     <= '0;
         host_row_q   <= '0;
         last_addr_q  <= '0;
         last_wdata_q <= '0;
      end else begin
         alive_q      <= 1'b1;
         count_q      <= count_d;
         head_q       <= head_d;
         age_q        <= age_d;
         tag_q        <= tag_d;
         fwd_q        <= fwd_d;
         fwd_row_q    <= fwd_row_d;
         rd_addr_q    <= rd_addr_d;
         last_addr_q  <= ram_addr;
         last_wdata_q <= ram_wdata;
         if (tag_q == TagLu)   rd_row_q   <= resp_row;
         if (tag_q == TagHost) host_row_q <= resp_row;
      end
   end

   // Buffer payload needs no reset: validity is carried by count_q.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_addr_q[wr_slot] <= bus.wr_addr_i;
         fifo_row_q[wr_slot]  <= bus.wr_row_i;
      end
   end

   assign bus.wr_ready_o     = alive_q && !full;
   assign bus.rd_req_ready_o = (gnt == GntRead);
   assign bus.host_ready_o   = (gnt == GntHost);
   assign bus.ram_en_o       = ram_en;
   assign bus.ram_we_o       = ram_we;
   assign bus.ram_addr_o     = ram_addr;
   assign bus.ram_wdata_o    = ram_wdata;
   assign bus.rd_row_valid_o = (tag_q == TagLu);
   assign bus.rd_row_addr_o  = rd_addr_q;
   assign bus.rd_row_o       = (tag_q == TagLu) ? resp_row : rd_row_q;
   assign bus.host_rvalid_o  = (tag_q == TagHost);
   assign bus.host_rdata_o   = (tag_q == TagHost) ? resp_row : host_row_q;
endmodule

// File: doc/lu_row_arbiter.md
LU_ROW_ARBITER -- requirements
Module: lu_row_arbiter

Interface
REQ-001 Parameters: SIZE, default 16, matrix dimension; WIDTH, default 64, bits per real/imag part; AGE_LIMIT, default 8, host starvation threshold in cycles.
REQ-002 Derived widths: RW = SIZE*2*WIDTH (one row, {imag,real} per element); AW = $clog2(SIZE).
REQ-003 clk_i  in  1  single clock, all state on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 rd_req_valid_i / rd_req_addr_i  in  1 / AW  LU row-read request.
REQ-006 rd_req_ready_o  out  1  read request granted this cycle.
REQ-007 rd_row_o / rd_row_addr_o / rd_row_valid_o  out  RW / AW / 1  read response, one cycle after grant.
REQ-008 wr_valid_i / wr_addr_i / wr_row_i  in  1 / AW / RW  LU row write-back.
REQ-009 wr_ready_o  out  1  write buffer not full.
REQ-010 host_valid_i / host_we_i / host_addr_i / host_wdata_i  in  1 / 1 / AW / RW  host load/unload request.
REQ-011 host_ready_o  out  1  host request granted this cycle.
REQ-012 host_rdata_o / host_rvalid_o  out  RW / 1  host read response, one cycle after grant.
REQ-013 ram_en_o / ram_we_o / ram_addr_o / ram_wdata_o  out  1 / 1 / AW / RW  single-port row RAM command.
REQ-014 ram_rdata_i  in  RW  RAM read data, valid one cycle after ram_en_o with ram_we_o low.

Function
REQ-015 Write buffer: 2-entry FIFO of {addr,row}; push when wr_valid_i and wr_ready_o; wr_ready_o = not full; a push and a drain in the same cycle when full is not allowed (wr_ready_o depends on registered count only).
REQ-016 One RAM slot per cycle; grant priority evaluated combinationally from registered state:
 - P1: FIFO full -> drain head;
 - P2: host aged (age counter == AGE_LIMIT) and host_valid_i -> host;
 - P3: rd_req_valid_i and not hazard-blocked -> LU read;
 - P4: FIFO non-empty -> drain head;
 - P5: host_valid_i -> host.
REQ-017 Drain: ram_en_o=1, ram_we_o=1, addr/data from FIFO head; pop same cycle.
REQ-018 Hazard: a read whose rd_req_addr_i matches any valid FIFO entry is hazard-blocked (behaviour set by REQ-029/030).
REQ-019 Host reads are hazard-checked identically; a blocked host read is not granted at P2/P5.
REQ-020 Age counter: increments each cycle host_valid_i=1 and host_ready_o=0, saturates at AGE_LIMIT, clears on host grant or host_valid_i=0.
REQ-021 Read response: registered tag {lu,host,none} plus addr; next cycle rd_row_o/host_rdata_o = ram_rdata_i with the matching valid high one cycle; the other valid stays 0.
REQ-022 rd_row_valid_o and host_rvalid_o are never high together; at most one of rd_req_ready_o, host_ready_o, drain is active per cycle.
REQ-023 Host write grant: ram_we_o=1 with host data; no response.
REQ-024 Idle cycle (no grant): ram_en_o=0, ram_we_o=0; ram_addr_o/ram_wdata_o hold last value.
REQ-025 Response data outputs hold last value when the valid is low.

Reset
REQ-026 While rst_i=1: FIFO emptied (pending writes discarded), age counter 0, response tag none.
REQ-027 Reset values: all *_valid_o, *_ready_o, ram_en_o, ram_we_o = 0; rd_row_o, host_rdata_o, ram_wdata_o = 0; all address outputs 0; wr_ready_o = 0 during reset, 1 from the first cycle after deassertion.
REQ-028 A response in flight when reset asserts is suppressed and never presented.

Configuration
REQ-029 Macro LU_ARB_FWD_EN defined: a hazard-blocked read is instead granted at its normal priority, ram_en_o=0 that cycle, and the next cycle returns the youngest matching FIFO entry's row with the normal one-cycle latency; the FIFO is unchanged.
REQ-030 Macro LU_ARB_FWD_EN undefined: a hazard-blocked read is not granted; P4 drain proceeds until no match remains, then the read is granted from RAM.

Verification
REQ-031 LU read addr 3 alone, RAM holds row R3 -> rd_req_ready_o cycle N, ram_en_o=1 ram_addr_o=3 cycle N, rd_row_valid_o=1 rd_row_o=R3 rd_row_addr_o=3 cycle N+1.
REQ-032 Two write-backs (addr 5, 6) then read requests every cycle -> FIFO full blocks wr_ready_o; drain of addr 5 at P1 precedes reads; both writes reach RAM in order 5,6.
REQ-033 Write addr 7 = W, then read addr 7 next cycle -> without LU_ARB_FWD_EN: drain first, read one cycle later returns W; with LU_ARB_FWD_EN: read granted immediately, ram_en_o=0, rd_row_o=W.
REQ-034 Host read addr 2 with LU reads asserted continuously -> host_ready_o no later than cycle AGE_LIMIT+1 (9) after host_valid_i rises; host_rvalid_o the cycle after.
REQ-035 Reset asserted the cycle after a read grant with 2 FIFO entries -> no rd_row_valid_o ever for that read; after deassertion no RAM writes occur; wr_ready_o=1.
